// File: rtl/random_request_arbiter.sv
// ---------------------------------------------------------------------------
// random_request_arbiter
//
// Shares one slow-stepping random source among N_REQ requesters. A winner is
// chosen round-robin. Its sample is optionally whitened with a 16-bit LFSR and
// then reduced into [0, limit) by repeated subtraction, one step per cycle.
// The result is returned with a one-cycle response pulse.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   req            per-requester request level, held until its response
//   limit_bus      packed exclusive upper bounds, VALUE_W bits per requester
//   src_value      current output of the random source
//   src_max_value  constant SRC_MAX for the source's max_value input
//   busy           high whenever the engine is not idle
//   rsp_valid      one-cycle result pulse
//   rsp_gnt        one-hot served requester (0 when rsp_valid is low)
//   rsp_id         index of served requester (0 when rsp_valid is low)
//   rsp_value      reduced result (0 when rsp_valid is low)
// ---------------------------------------------------------------------------
module random_request_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned ID_W      = 2,
    parameter int unsigned VALUE_W   = 9,
    parameter logic [31:0] SRC_MAX   = 32'd480,
    parameter bit          MIX_EN    = 1'b1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*VALUE_W-1:0]   limit_bus,
    input  logic [VALUE_W-1:0]         src_value,
    output logic [31:0]                src_max_value,
    output logic                       busy,
    output logic                       rsp_valid,
    output logic [N_REQ-1:0]           rsp_gnt,
    output logic [ID_W-1:0]            rsp_id,
    output logic [VALUE_W-1:0]         rsp_value
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Register state
    state_t               state_q,     state_d;
    logic [ID_W-1:0]      rr_ptr_q,    rr_ptr_d;
    logic [15:0]          lfsr_q,      lfsr_d;
    logic [VALUE_W-1:0]   val_q,       val_d;
    logic [VALUE_W-1:0]   lim_q,       lim_d;
    logic [ID_W-1:0]      id_q,        id_d;
    logic                 busy_q,      busy_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [N_REQ-1:0]     rsp_gnt_q,   rsp_gnt_d;
    logic [ID_W-1:0]      rsp_id_q,    rsp_id_d;
    logic [VALUE_W-1:0]   rsp_value_q, rsp_value_d;

    // Arbitration helpers
    logic                 found;
    logic [ID_W-1:0]      winner;
    logic [VALUE_W-1:0]   win_limit;
    logic [VALUE_W-1:0]   sample;
    logic                 lfsr_fb;

    assign src_max_value = SRC_MAX;

    // Fibonacci LFSR, taps 16,14,13,11, shifting left with feedback into bit 0
    always_comb begin
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d  = {lfsr_q[14:0], lfsr_fb};
    end

    // Whitened (or raw) sample as seen at the grant edge
    always_comb begin
        if (MIX_EN) begin
            sample = src_value ^ lfsr_q[VALUE_W-1:0];
        end else begin
            sample = src_value;
        end
    end

    // Round-robin pick: first set request at or above rr_ptr, wrapping
    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(rr_ptr_q) + i) % N_REQ;
            if (!found && req[ID_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // Limit slice of the winner, constant-index selection
    always_comb begin
        win_limit = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_limit = limit_bus[i*VALUE_W +: VALUE_W];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        val_d       = val_q;
        lim_d       = lim_q;
        id_d        = id_q;
        rsp_valid_d = 1'b0;
        rsp_gnt_d   = '0;
        rsp_id_d    = '0;
        rsp_value_d = '0;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    id_d    = winner;
                    lim_d   = win_limit;
                    val_d   = sample;
                    state_d = REDUCE;
                    if (winner == ID_W'(N_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = winner + ID_W'(1);
                    end
                end
            end

            REDUCE: begin
                // Response registers load on the edge that enters DONE
                if (lim_q == '0) begin
                    val_d       = '0;
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_gnt_d   = N_REQ'(1) << id_q;
                    rsp_id_d    = id_q;
                    rsp_value_d = '0;
                end else if (val_q >= lim_q) begin
                    val_d = val_q - lim_q;
                end else begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_gnt_d   = N_REQ'(1) << id_q;
                    rsp_id_d    = id_q;
                    rsp_value_d = val_q;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            lfsr_q      <= LFSR_SEED;
            val_q       <= '0;
            lim_q       <= '0;
            id_q        <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_gnt_q   <= '0;
            rsp_id_q    <= '0;
            rsp_value_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lfsr_q      <= lfsr_d;
            val_q       <= val_d;
            lim_q       <= lim_d;
            id_q        <= id_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_gnt_q   <= rsp_gnt_d;
            rsp_id_q    <= rsp_id_d;
            rsp_value_q <= rsp_value_d;
        end
    end

    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_gnt   = rsp_gnt_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_value = rsp_value_q;

endmodule

// File: tb/tb_random_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_random_request_arbiter
//
// Two instances: dut0 with raw samples (MIX_EN=0) for arithmetic and
// arbitration, dut1 with mixing enabled for the LFSR whitening case.
// Expected responses are queued when requests are driven and popped by a
// per-instance monitor on the falling edge.
// ---------------------------------------------------------------------------
module tb_random_request_arbiter;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned VALUE_W = 9;

    typedef struct {
        int id;
        int val;
        int lat;   // expected cycles from grant edge to monitor sample, -1 = unchecked
        int e0;    // cycle count at the grant edge
    } exp_t;

    logic clk;
    logic reset;

    logic [N_REQ-1:0]         req0,  req1;
    logic [N_REQ*VALUE_W-1:0] lbus0, lbus1;
    logic [VALUE_W-1:0]       src0,  src1;
    logic [31:0]              max0,  max1;
    logic                     busy0, busy1;
    logic                     v0,    v1;
    logic [N_REQ-1:0]         gnt0,  gnt1;
    logic [ID_W-1:0]          id0,   id1;
    logic [VALUE_W-1:0]       val0,  val1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0_ent, e1_ent;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;

    random_request_arbiter #(
        .N_REQ(N_REQ), .ID_W(ID_W), .VALUE_W(VALUE_W),
        .SRC_MAX(32'd480), .MIX_EN(1'b0), .LFSR_SEED(16'hACE1)
    ) dut0 (
        .clk(clk), .reset(reset), .req(req0), .limit_bus(lbus0),
        .src_value(src0), .src_max_value(max0), .busy(busy0),
        .rsp_valid(v0), .rsp_gnt(gnt0), .rsp_id(id0), .rsp_value(val0)
    );

    random_request_arbiter #(
        .N_REQ(N_REQ), .ID_W(ID_W), .VALUE_W(VALUE_W),
        .SRC_MAX(32'd480), .MIX_EN(1'b1), .LFSR_SEED(16'hACE1)
    ) dut1 (
        .clk(clk), .reset(reset), .req(req1), .limit_bus(lbus1),
        .src_value(src1), .src_max_value(max1), .busy(busy1),
        .rsp_valid(v1), .rsp_gnt(gnt1), .rsp_id(id1), .rsp_value(val1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    // dut0 response monitor
    always @(negedge clk) begin
        chk("src_max0", max0, 32'd480);
        if (v0) begin
            if (prev0) chk("back_to_back0", 32'(v0), 32'd0);
            if (q0.size() == 0) begin
                chk("unexpected_rsp0", 32'd1, 32'd0);
            end else begin
                e0_ent = q0.pop_front();
                chk("rsp_id0",    32'(id0),  32'(e0_ent.id));
                chk("rsp_gnt0",   32'(gnt0), 32'(1) << e0_ent.id);
                chk("rsp_value0", 32'(val0), 32'(e0_ent.val));
                if (e0_ent.lat >= 0) chk("latency0", 32'(cyc - e0_ent.e0), 32'(e0_ent.lat));
            end
        end else begin
            chk("idle_zero0", 32'({gnt0, id0, val0}), 32'd0);
        end
        prev0 = v0;
    end

    // dut1 response monitor
    always @(negedge clk) begin
        chk("src_max1", max1, 32'd480);
        if (v1) begin
            if (prev1) chk("back_to_back1", 32'(v1), 32'd0);
            if (q1.size() == 0) begin
                chk("unexpected_rsp1", 32'd1, 32'd0);
            end else begin
                e1_ent = q1.pop_front();
                chk("rsp_id1",    32'(id1),  32'(e1_ent.id));
                chk("rsp_gnt1",   32'(gnt1), 32'(1) << e1_ent.id);
                chk("rsp_value1", 32'(val1), 32'(e1_ent.val));
                if (e1_ent.lat >= 0) chk("latency1", 32'(cyc - e1_ent.e0), 32'(e1_ent.lat));
            end
        end else begin
            chk("idle_zero1", 32'({gnt1, id1, val1}), 32'd0);
        end
        prev1 = v1;
    end

    // Wait on posedges until the chosen scoreboard drains, bounded
    task automatic wait_drain(input int which, input int budget);
        int n = 0;
        while (((which == 0) ? q0.size() : q1.size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk((which == 0) ? "drain0" : "drain1",
            32'((which == 0) ? q0.size() : q1.size()), 32'd0);
    endtask

    function automatic exp_t mk(input int id, input int val, input int lat, input int e0);
        exp_t e;
        e.id  = id;
        e.val = val;
        e.lat = lat;
        e.e0  = e0;
        return e;
    endfunction

    // Reference reduction for raw samples
    function automatic int model_reduce(input int s, input int lim);
        return (lim == 0) ? 0 : (s % lim);
    endfunction

    initial begin
        reset = 1'b1;
        req0  = '0;
        lbus0 = '0;
        src0  = '0;
        req1  = 4'b0001;
        lbus1 = '0;
        lbus1[0 +: VALUE_W] = 9'd511;
        src1  = '0;

        // Reset and configuration
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy0",  32'(busy0), 32'd0);
        chk("rst_busy1",  32'(busy1), 32'd0);
        chk("rst_valid0", 32'(v0),    32'd0);
        chk("rst_value0", 32'(val0),  32'd0);

        // Mixing: request present on the first edge after release, seed low bits 0x0E1
        reset = 1'b0;
        q1.push_back(mk(0, 225, 1, cyc + 1));
        wait_drain(1, 20);
        #1 req1 = '0;

        // Round robin, all requesters held
        for (int i = 0; i < int'(N_REQ); i++) lbus0[i*VALUE_W +: VALUE_W] = 9'd7;
        src0 = 9'd3;
        req0 = 4'b1111;
        for (int i = 0; i < 5; i++) q0.push_back(mk(i % int'(N_REQ), model_reduce(3, 7), -1, 0));
        wait_drain(0, 200);
        #1 req0 = '0;

        // Single request with two subtractions
        lbus0[0 +: VALUE_W] = 9'd100;
        src0 = 9'd250;
        req0 = 4'b0001;
        q0.push_back(mk(0, model_reduce(250, 100), 3, cyc + 1));
        wait_drain(0, 50);
        #1 req0 = '0;

        // Zero limit
        lbus0[2*VALUE_W +: VALUE_W] = 9'd0;
        src0 = 9'd311;
        req0 = 4'b0100;
        q0.push_back(mk(2, 0, 1, cyc + 1));
        wait_drain(0, 50);
        #1 req0 = '0;

        // Reset during a long reduction aborts it silently
        lbus0[1*VALUE_W +: VALUE_W] = 9'd1;
        src0 = 9'd511;
        req0 = 4'b0010;
        repeat (100) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy0), 32'd1);
        reset = 1'b1;
        req0  = 4'b1001;
        lbus0[0*VALUE_W +: VALUE_W] = 9'd10;
        lbus0[3*VALUE_W +: VALUE_W] = 9'd20;
        @(posedge clk);
        #1;
        chk("abort_busy",  32'(busy0), 32'd0);
        chk("abort_valid", 32'(v0),    32'd0);
        reset = 1'b0;
        q0.push_back(mk(0, model_reduce(511, 10), 52, cyc + 1));
        q0.push_back(mk(3, model_reduce(511, 20), -1, 0));
        wait_drain(0, 400);
        #1 req0 = '0;

        repeat (5) @(posedge clk);
        #1;
        chk("final_busy0", 32'(busy0), 32'd0);
        chk("final_q0",    32'(q0.size()), 32'd0);
        chk("final_q1",    32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
